tm1638_responder: RTL
=====================

TM1638_RESPONDER -- requirements
Module: tm1638_responder

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, meaning the synchronizer depth (2..4) on stb_i, sclk_i and dio_i.
REQ-002 SHALL have parameter RESET_BRIGHT, default 3'd0, meaning the brightness_o value after reset.
REQ-003 SHALL have a single clock domain on clk, with a synchronous, active-high reset on reset.
REQ-004 clk  input  1  system clock; frequency at least 8x the sclk_i rate.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 stb_i  input  1  TM1638 strobe, active low, asynchronous.
REQ-007 sclk_i  input  1  TM1638 serial clock, asynchronous.
REQ-008 dio_i  input  1  serial data from the initiator, LSB first.
REQ-009 dio_o  output  1  serial key data to the initiator.
REQ-010 dio_oe_o  output  1  dio_o drive enable.
REQ-011 keys_i  input  32  key-scan bytes; byte0 = [7:0] is sent first.
REQ-012 rd_addr_i  input  4  display RAM read address.
REQ-013 rd_data_o  output  8  display RAM byte at rd_addr_i, registered with 1-cycle latency.
REQ-014 wr_stb_o  output  1  one-cycle pulse on each display RAM write.
REQ-015 wr_addr_o / wr_data_o  output  4 / 8  address and data of the last write.
REQ-016 disp_on_o  output  1  display enable from the last display-control command.
REQ-017 brightness_o  output  3  brightness from the last display-control command.
REQ-018 frame_err_o  output  1  one-cycle pulse when stb_i rises mid-byte.

Function
REQ-019 Bits SHALL be sampled on the synchronized rising edge of sclk_i while stb_i is low; edges while stb_i is high SHALL be ignored.
REQ-020 The FSM SHALL have four states: IDLE, CMD, WR_DATA and KEY_RD.
REQ-021 In the FSM, a falling edge of stb_i SHALL move IDLE to CMD, and a rising edge of stb_i SHALL return any state to IDLE.
REQ-022 In CMD, the 8th bit SHALL decode cmd[7:6] as follows: 01 selects the data command, 10 selects display control, and 11 selects address set.
REQ-023 For a data command, bit1=1 SHALL enter KEY_RD (if enabled) and bit1=0 SHALL enter WR_DATA; bit2 SHALL select fixed addressing (1) or auto-increment (0), and the selected mode SHALL persist until the next data command.
REQ-024 Display control SHALL latch disp_on_o = cmd[3] and brightness_o = cmd[2:0], then wait for stb_i to rise.
REQ-025 Address set SHALL load address pointer = cmd[3:0] and enter WR_DATA.
REQ-026 In WR_DATA, each completed byte SHALL write RAM[ptr] and pulse wr_stb_o exactly 1 clk after the internal edge detect of its 8th bit.
REQ-027 In WR_DATA, ptr SHALL increment after each byte in auto mode, wrapping from 15 to 0.
REQ-028 On entry to KEY_RD, keys_i SHALL be snapshotted.
REQ-029 In KEY_RD, dio_oe_o SHALL assert and bit0 of byte0 SHALL be driven at the first sclk falling edge after the command byte; each subsequent falling edge SHALL advance one bit.
REQ-030 In KEY_RD, after 32 bits dio_o SHALL drive 0.
REQ-031 When stb_i rises before 8 bits are received, the partial byte SHALL be discarded, no write SHALL occur, and frame_err_o SHALL pulse.
REQ-032 When stb_i rises in the same cycle as an 8th sclk edge, the byte SHALL be accepted first, then the FSM SHALL go to IDLE.
REQ-033 dio_oe_o SHALL deassert within 1 clk of the synchronized stb_i rising.

Reset
REQ-034 Reset SHALL set the FSM to IDLE, ptr to 0, mode to auto-increment, RAM to 0x00, dio_o to 0, dio_oe_o to 0, wr_stb_o to 0, wr_addr_o to 0, wr_data_o to 0, frame_err_o to 0, disp_on_o to 0 and brightness_o to RESET_BRIGHT.
REQ-035 Reset asserted mid-frame SHALL abort the frame; the block SHALL then ignore sclk_i until the next falling edge of stb_i.

Configuration
REQ-036 With macro TM1638_RESPONDER_KEYREAD_EN defined, the KEY_RD path SHALL be implemented.
REQ-037 Without TM1638_RESPONDER_KEYREAD_EN, dio_oe_o and dio_o SHALL be tied to 0, keys_i SHALL be unused, and a read command SHALL go to a wait-for-stb_i-high state without writes.

Structure
REQ-038 Package tm1638_pkg SHALL hold the command field constants (CMD_DATA, CMD_DISP, CMD_ADDR, bit positions) and the FSM state encoding.
REQ-039 Sub-module tm1638_sync_edge SHALL provide an SYNC_STAGES-deep synchronizer with rise/fall pulses, instantiated once per input pin.

Verification
REQ-040 Frame 0x40, then frame 0xC0 followed by 0x3F, 0x06, 0x5B -> RAM[0..2] = 3F,06,5B and three wr_stb_o pulses with addresses 0,1,2.
REQ-041 Frame 0x44, then frame 0xCF followed by 0x11, 0x22 -> RAM[15] = 0x22, two pulses both at address 15; with 0x40 instead, the addresses are 15 then 0 (wrap).
REQ-042 Frame 0x8A -> disp_on_o = 1 and brightness_o = 2, with no RAM write.
REQ-043 With keys_i = 0x80402001, frame 0x42 then 32 clocks -> initiator reads bytes 01,20,40,80 LSB first and dio_oe_o is high for the whole read phase.
REQ-044 Frame 0xC3 followed by 5 bits of 0x55 and then stb_i rising -> frame_err_o pulses once, RAM[3] is unchanged and wr_stb_o stays 0.
REQ-045 Reset asserted during the 2nd data byte -> all outputs return to reset values, and the next full frame is decoded correctly.

Source files
------------

// File: rtl/tm1638_pkg.sv
// Shared TM1638 command-field constants and responder FSM encoding.
// Pure declarations: no logic, no latency.
package tm1638_pkg;

  localparam logic [1:0] CMD_DATA = 2'b01;
  localparam logic [1:0] CMD_DISP = 2'b10;
  localparam logic [1:0] CMD_ADDR = 2'b11;

  localparam int CMD_TYPE_MSB   = 7;
  localparam int CMD_TYPE_LSB   = 6;
  localparam int DATA_FIXED_BIT = 2;
  localparam int DATA_READ_BIT  = 1;
  localparam int DISP_ON_BIT    = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CMD     = 2'd1,
    WR_DATA = 2'd2,
    KEY_RD  = 2'd3
  } state_t;

  function automatic logic [1:0] cmd_type(input logic [7:0] b);
    return b[CMD_TYPE_MSB:CMD_TYPE_LSB];
  endfunction

endpackage

// File: rtl/tm1638_sync_edge.sv
// Multi-stage synchronizer for one asynchronous pin with rise/fall pulses.
// Latency STAGES clk to lvl, edge pulses one cycle wide; no backpressure.
module tm1638_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic lvl,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sr;
  logic              lvl_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sr    <= {STAGES{RST_VAL}};
      lvl_q <= RST_VAL;
    end else begin
      sr    <= {sr[STAGES-2:0], din};
      lvl_q <= sr[STAGES-1];
    end
  end

  assign lvl  = sr[STAGES-1];
  assign rise = lvl & ~lvl_q;
  assign fall = ~lvl & lvl_q;

endmodule

// File: rtl/tm1638_responder.sv
// TM1638 peripheral responder: command decode, 16-byte display RAM, key read-back
// (key read only with TM1638_RESPONDER_KEYREAD_EN); writes pulse 1 clk after the 8th bit edge.
module tm1638_responder
  import tm1638_pkg::*;
#(
  parameter int         SYNC_STAGES  = 2,
  parameter logic [2:0] RESET_BRIGHT = 3'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stb_i,
  input  logic        sclk_i,
  input  logic        dio_i,
  output logic        dio_o,
  output logic        dio_oe_o,
  input  logic [31:0] keys_i,
  input  logic [3:0]  rd_addr_i,
  output logic [7:0]  rd_data_o,
  output logic        wr_stb_o,
  output logic [3:0]  wr_addr_o,
  output logic [7:0]  wr_data_o,
  output logic        disp_on_o,
  output logic [2:0]  brightness_o,
  output logic        frame_err_o
);

  logic stb_lvl_unused, stb_rise, stb_fall;
  logic sclk_lvl_unused, sclk_rise, sclk_fall;
  logic dio_lvl, dio_rise_unused, dio_fall_unused;

  // stb resets low so a strobe already low when reset releases yields no falling edge.
  tm1638_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_stb (
    .clk(clk), .reset(reset), .din(stb_i),
    .lvl(stb_lvl_unused), .rise(stb_rise), .fall(stb_fall)
  );
  tm1638_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_sclk (
    .clk(clk), .reset(reset), .din(sclk_i),
    .lvl(sclk_lvl_unused), .rise(sclk_rise), .fall(sclk_fall)
  );
  tm1638_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_dio (
    .clk(clk), .reset(reset), .din(dio_i),
    .lvl(dio_lvl), .rise(dio_rise_unused), .fall(dio_fall_unused)
  );

  state_t      state, state_nxt;
  logic [2:0]  bit_cnt;
  logic [7:0]  shreg;
  logic [3:0]  ptr;
  logic        fixed_mode;
  logic [7:0]  ram [16];
  logic        rx_active, bit_en, byte_done, ram_we;
  logic [7:0]  rx_byte;

  // IDLE doubles as the wait-for-strobe-high state: it ignores sclk edges.
  assign rx_active = (state == CMD) || (state == WR_DATA);
  assign bit_en    = rx_active && sclk_rise;
  assign byte_done = bit_en && (bit_cnt == 3'd7);
  assign rx_byte   = {dio_lvl, shreg[7:1]};
  assign ram_we    = byte_done && (state == WR_DATA);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (stb_fall) state_nxt = CMD;
      CMD: begin
        if (byte_done) begin
          case (cmd_type(rx_byte))
            CMD_DATA: begin
              if (!rx_byte[DATA_READ_BIT]) state_nxt = WR_DATA;
`ifdef TM1638_RESPONDER_KEYREAD_EN
              else                         state_nxt = KEY_RD;
`else
              else                         state_nxt = IDLE;
`endif
            end
            CMD_ADDR: state_nxt = WR_DATA;
            default:  state_nxt = IDLE;
          endcase
        end
      end
      default: state_nxt = state;
    endcase
    // A byte completing together with the strobe rise is still taken above.
    if (stb_rise) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      bit_cnt      <= 3'd0;
      shreg        <= 8'h00;
      ptr          <= 4'd0;
      fixed_mode   <= 1'b0;
      wr_stb_o     <= 1'b0;
      wr_addr_o    <= 4'd0;
      wr_data_o    <= 8'h00;
      frame_err_o  <= 1'b0;
      disp_on_o    <= 1'b0;
      brightness_o <= RESET_BRIGHT;
    end else begin
      state       <= state_nxt;
      wr_stb_o    <= ram_we;
      frame_err_o <= stb_rise && rx_active && (bit_cnt != 3'd0) && !byte_done;
      if (stb_fall) begin
        bit_cnt <= 3'd0;
      end else if (bit_en) begin
        bit_cnt <= bit_cnt + 3'd1;
        shreg   <= rx_byte;
      end
      if (byte_done && state == CMD) begin
        case (cmd_type(rx_byte))
          CMD_DATA: fixed_mode <= rx_byte[DATA_FIXED_BIT];
          CMD_DISP: begin
            disp_on_o    <= rx_byte[DISP_ON_BIT];
            brightness_o <= rx_byte[2:0];
          end
          CMD_ADDR: ptr <= rx_byte[3:0];
          default: ;
        endcase
      end
      if (ram_we) begin
        wr_addr_o <= ptr;
        wr_data_o <= rx_byte;
        if (!fixed_mode) ptr <= ptr + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) ram[i] <= 8'h00;
      rd_data_o <= 8'h00;
    end else begin
      if (ram_we) ram[ptr] <= rx_byte;
      rd_data_o <= ram[rd_addr_i];
    end
  end

`ifdef TM1638_RESPONDER_KEYREAD_EN
  logic [31:0] key_snap;
  logic [5:0]  key_idx;

  always_ff @(posedge clk) begin
    if (reset) begin
      key_snap <= 32'h0;
      key_idx  <= 6'd0;
      dio_o    <= 1'b0;
      dio_oe_o <= 1'b0;
    end else begin
      if (state == CMD && state_nxt == KEY_RD) begin
        key_snap <= keys_i;
        key_idx  <= 6'd0;
      end
      if (state != KEY_RD || stb_rise) begin
        dio_oe_o <= 1'b0;
        dio_o    <= 1'b0;
      end else if (sclk_fall) begin
        dio_oe_o <= 1'b1;
        dio_o    <= key_idx[5] ? 1'b0 : key_snap[key_idx[4:0]];
        if (!key_idx[5]) key_idx <= key_idx + 6'd1;
      end
    end
  end
`else
  logic unused_inputs;
  assign unused_inputs = ^{keys_i, sclk_fall};
  assign dio_o    = 1'b0;
  assign dio_oe_o = 1'b0;
`endif

endmodule
